// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulo counter family.
package counter_pkg;

    typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;

    localparam int unsigned CNT_MIN_MODULUS = 32'd2;
    localparam int unsigned CNT_MIN_WIDTH   = 32'd2;

    // Out-of-range load values saturate at the top of the count range.
    function automatic int unsigned clamp_load(input int unsigned value, input int unsigned modulus);
        int unsigned r;
        if (value > (modulus - 32'd1)) begin
            r = modulus - 32'd1;
        end else begin
            r = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-count and terminal-count logic for counter_updown_mod.
// COUNTER_UPDOWN_SAT_EN selects saturate-at-limit instead of modulo wrap.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_next_count,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef COUNTER_UPDOWN_SAT_EN
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = MAX_C;
    localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = ZERO_C;
    localparam logic             WRAP_EN         = 1'b0;
`else
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = ZERO_C;
    localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = MAX_C;
    localparam logic             WRAP_EN         = 1'b1;
`endif

    cnt_dir_e         w_dir;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_limit;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_dir          = cnt_dir_e'(i_up);
    assign w_at_max       = (i_count == MAX_C);
    assign w_at_zero      = (i_count == ZERO_C);
    assign w_load_clamped = WIDTH'(clamp_load(32'(i_load_value), MODULUS));

    // One enabled step in the selected direction, handling the range limit.
    always_comb begin
        w_limit = 1'b0;
        w_step  = i_count;
        case (w_dir)
            CNT_UP: begin
                w_limit = w_at_max;
                if (w_at_max) begin
                    w_step = UP_LIMIT_NEXT;
                end else begin
                    w_step = i_count + ONE_C;
                end
            end
            CNT_DOWN: begin
                w_limit = w_at_zero;
                if (w_at_zero) begin
                    w_step = DOWN_LIMIT_NEXT;
                end else begin
                    w_step = i_count - ONE_C;
                end
            end
            default: begin
                w_limit = 1'b0;
                w_step  = i_count;
            end
        endcase
    end

    // Edge priority: load, then count enable, then hold.
    always_comb begin
        o_next_count = i_count;
        if (i_load) begin
            o_next_count = w_load_clamped;
        end else if (i_en) begin
            o_next_count = w_step;
        end else begin
            o_next_count = i_count;
        end
    end

    assign o_tc   = i_en & ~i_load & w_limit;
    assign o_wrap = o_tc & WRAP_EN;

endmodule

// File: rtl/counter_updown_mod.sv
// WIDTH-bit up/down counter with programmable modulus, load, enable, tc and wrap pulse.
// Define COUNTER_UPDOWN_SAT_EN for saturating instead of wrapping behaviour.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    if (WIDTH < int'(CNT_MIN_WIDTH)) begin : g_bad_width
        $error("counter_updown_mod: WIDTH must be at least 2");
    end
    if ((MODULUS < int'(CNT_MIN_MODULUS)) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("counter_updown_mod: MODULUS must lie in 2 .. 2**WIDTH");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_next_count;
    logic             w_tc;
    logic             w_wrap;

    counter_next_val #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_val (
        .i_count      (r_count),
        .i_en         (en),
        .i_up         (up),
        .i_load       (load),
        .i_load_value (load_value),
        .o_next_count (w_next_count),
        .o_tc         (w_tc),
        .o_wrap       (w_wrap)
    );

    // Count and wrap-pulse state; clear_n discards everything immediately.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_count   <= {WIDTH{1'b0}};
            r_wrapped <= 1'b0;
        end else begin
            r_count   <= w_next_count;
            r_wrapped <= w_wrap;
        end
    end

    assign count   = r_count;
    assign tc      = w_tc;
    assign wrapped = r_wrapped;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed self-checking bench: instance A is WIDTH=4/MODULUS=10, instance B is WIDTH=4/MODULUS=16.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       en_a, up_a, load_a, en_b, up_b, load_b;
    logic [3:0] lv_a, lv_b;
    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, wrapped_a, wrapped_b;

    int n_cmp = 0;
    int n_err = 0;

    int exp_up_cnt[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_up_tc [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exp_up_wr [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exp_dn_cnt[4]  = '{1, 0, 9, 8};
    int exp_dn_tc [4]  = '{0, 0, 1, 0};
    int exp_dn_wr [4]  = '{0, 0, 1, 0};
`ifdef COUNTER_UPDOWN_SAT_EN
    int exp_b_cnt[4]   = '{15, 15, 15, 15};
    int exp_b_wr [4]   = '{0, 0, 0, 0};
    int exp_b_low_cnt  = 0;
    int exp_b_low_wr   = 0;
`else
    int exp_b_cnt[4]   = '{15, 0, 1, 2};
    int exp_b_wr [4]   = '{0, 1, 0, 0};
    int exp_b_low_cnt  = 15;
    int exp_b_low_wr   = 1;
`endif

    counter_updown_mod #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .clear_n(clear_n), .en(en_a), .up(up_a), .load(load_a),
        .load_value(lv_a), .count(count_a), .tc(tc_a), .wrapped(wrapped_a)
    );

    counter_updown_mod #(.WIDTH(4), .MODULUS(16)) dut_b (
        .clk(clk), .clear_n(clear_n), .en(en_b), .up(up_b), .load(load_b),
        .load_value(lv_b), .count(count_b), .tc(tc_b), .wrapped(wrapped_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_n = 1'b0;
        en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; lv_a = 4'd0;
        en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; lv_b = 4'd0;
        tick();
        tick();
        check("rst_count_a", int'(count_a), 0);
        check("rst_wrapped_a", int'(wrapped_a), 0);
        check("rst_tc_a", int'(tc_a), 0);
        check("rst_count_b", int'(count_b), 0);

        // Asynchronous reset in the middle of a cycle at count=7
        @(negedge clk);
        clear_n = 1'b1;
        load_a = 1'b1; lv_a = 4'd7;
        tick();
        load_a = 1'b0;
        check("load7", int'(count_a), 7);
        #2 clear_n = 1'b0;
        #1 check("async_clr_count", int'(count_a), 0);

        // Produce a wrapped pulse, then clear it asynchronously
        @(negedge clk);
        clear_n = 1'b1;
        load_a = 1'b1; lv_a = 4'd0;
        tick();
        load_a = 1'b0; en_a = 1'b1; up_a = 1'b0;
        #1 check("tc_at_zero_down", int'(tc_a), 1);
        tick();
        check("down_from_zero", int'(count_a), 9);
        check("down_from_zero_wr", int'(wrapped_a), 1);
        en_a = 1'b0;
        #2 clear_n = 1'b0;
        #1 check("async_clr_cnt9", int'(count_a), 0);
        check("async_clr_wr", int'(wrapped_a), 0);

        // Reset held two clocks with enable active
        en_a = 1'b1; up_a = 1'b1;
        tick();
        tick();
        check("held_rst_count", int'(count_a), 0);
        @(negedge clk);
        clear_n = 1'b1;

        // Up wrap
        for (int i = 0; i < 12; i++) begin
            check("up_tc", int'(tc_a), exp_up_tc[i]);
            tick();
            check("up_count", int'(count_a), exp_up_cnt[i]);
            check("up_wrapped", int'(wrapped_a), exp_up_wr[i]);
        end

        // Down wrap from a loaded 2
        en_a = 1'b0; load_a = 1'b1; lv_a = 4'd2;
        tick();
        load_a = 1'b0;
        check("load2", int'(count_a), 2);
        check("load2_wr", int'(wrapped_a), 0);
        en_a = 1'b1; up_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("dn_tc", int'(tc_a), exp_dn_tc[i]);
            tick();
            check("dn_count", int'(count_a), exp_dn_cnt[i]);
            check("dn_wrapped", int'(wrapped_a), exp_dn_wr[i]);
        end

        // Load priority and clamp
        load_a = 1'b1; lv_a = 4'd13; en_a = 1'b1; up_a = 1'b1;
        #1 check("load_tc", int'(tc_a), 0);
        tick();
        check("clamp13", int'(count_a), 9);
        lv_a = 4'd5;
        #1 check("load_at_max_tc", int'(tc_a), 0);
        tick();
        check("load5", int'(count_a), 5);
        check("load5_wr", int'(wrapped_a), 0);

        // Hold then direction switch
        lv_a = 4'd4;
        tick();
        load_a = 1'b0; en_a = 1'b0; up_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_count", int'(count_a), 4);
            check("hold_tc", int'(tc_a), 0);
        end
        en_a = 1'b1; up_a = 1'b1;
        tick();
        check("dir_up", int'(count_a), 5);
        up_a = 1'b0;
        tick();
        check("dir_down", int'(count_a), 4);
        up_a = 1'b1;
        tick();
        check("dir_up2", int'(count_a), 5);
        en_a = 1'b0;

        // Full-range instance: natural overflow or saturation
        load_b = 1'b1; lv_b = 4'd14;
        tick();
        check("b_load14", int'(count_b), 14);
        load_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_up_count", int'(count_b), exp_b_cnt[i]);
            check("b_up_wrapped", int'(wrapped_b), exp_b_wr[i]);
        end
        en_b = 1'b0; load_b = 1'b1; lv_b = 4'd1;
        tick();
        load_b = 1'b0; en_b = 1'b1; up_b = 1'b0;
        tick();
        check("b_down_to0", int'(count_b), 0);
        #1 check("b_tc_at0", int'(tc_b), 1);
        tick();
        check("b_down_low", int'(count_b), exp_b_low_cnt);
        check("b_down_low_wr", int'(wrapped_b), exp_b_low_wr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
